// File: rtl/chip_reset_seq_pkg.sv
// chip_reset_pkg: shared state encoding, default timing constants and the
// counter sizing helper for the chip reset sequencer.
package chip_reset_pkg;

    typedef enum logic [1:0] {
        RS_HOLD    = 2'd0,
        RS_STABLE  = 2'd1,
        RS_RELEASE = 2'd2,
        RS_RUN     = 2'd3
    } rs_state_e;

    localparam int unsigned DEF_SYNC_STAGES        = 2;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_RESET_HOLD_CYCLES  = 64;
    localparam int unsigned DEF_HEARTBEAT_BIT      = 24;

    // Width of a counter that must reach the larger of the two terminals.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/chip_reset_seq_if.sv
// chip_reset_seq_if: harness-facing signals of the reset sequencer.
// slave is the sequencer side, master is the harness/board side.
interface chip_reset_seq_if;

    logic       locked_i;
    logic       success_i;
    logic       sys_reset_o;
    logic       led_o;
    logic [1:0] state_o;

    modport slave (
        input  locked_i,
        input  success_i,
        output sys_reset_o,
        output led_o,
        output state_o
    );

    modport master (
        output locked_i,
        output success_i,
        input  sys_reset_o,
        input  led_o,
        input  state_o
    );

endinterface

// File: rtl/chip_bit_sync.sv
// chip_bit_sync: single-bit multi-flop synchronizer into the clock domain,
// cleared to 0 by the asynchronous active-low reset.
module chip_bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/chip_reset_seq.sv
// chip_reset_seq: waits for a stable clock-wizard lock, holds the system
// reset for a further period, re-asserts it on lock loss, and drives the
// status LED from the latched harness success flag.
// Optional feature macro: CHIP_RESET_SEQ_HEARTBEAT_EN (LED blinks while
// running, goes solid on success).
module chip_reset_seq
    import chip_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int unsigned HEARTBEAT_BIT      = DEF_HEARTBEAT_BIT
) (
    input  logic             clock,
    input  logic             resetn,
    chip_reset_seq_if.slave  harness
);

    localparam int unsigned CW = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);

    logic          locked_s;
    rs_state_e     state_q;
    rs_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          succ_q;
    logic          succ_d;
    logic          sys_reset_q;
    logic          led_q;
    logic          led_d;

    chip_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (harness.locked_i),
        .q      (locked_s)
    );

    // State and cycle counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RS_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; lock loss beats any count terminal.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            RS_HOLD: begin
                if (locked_s) begin
                    state_d = RS_STABLE;
                end
            end
            RS_STABLE: begin
                if (!locked_s) begin
                    state_d = RS_HOLD;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = RS_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RS_RELEASE: begin
                if (!locked_s) begin
                    state_d = RS_HOLD;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RS_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RS_RUN: begin
                if (!locked_s) begin
                    state_d = RS_HOLD;
                end
            end
            default: begin
                state_d = RS_HOLD;
            end
        endcase
    end

    // Success is sticky while running and dropped on any exit from RUN.
    always_comb begin
        succ_d = 1'b0;
        if (state_d == RS_RUN) begin
            succ_d = succ_q | ((state_q == RS_RUN) & harness.success_i);
        end
    end

`ifdef CHIP_RESET_SEQ_HEARTBEAT_EN
    logic [HEARTBEAT_BIT:0] hb_q;

    // Heartbeat runs only in RUN so each run starts its blink from zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hb_q <= '0;
        end else if (state_q != RS_RUN) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_q + 1'b1;
        end
    end

    // Solid on success, blinking while running, dark otherwise.
    always_comb begin
        led_d = 1'b0;
        if (succ_d) begin
            led_d = 1'b1;
        end else if (state_d == RS_RUN) begin
            led_d = hb_q[HEARTBEAT_BIT];
        end
    end
`else
    localparam int unsigned UNUSED_HB_BIT = HEARTBEAT_BIT;

    // LED shows only the latched success flag.
    always_comb begin
        led_d = succ_d;
    end
`endif

    // Registered outputs: reset released exactly on the edge RUN is entered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sys_reset_q <= 1'b1;
            succ_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            sys_reset_q <= (state_d != RS_RUN);
            succ_q      <= succ_d;
            led_q       <= led_d;
        end
    end

    assign harness.sys_reset_o = sys_reset_q;
    assign harness.led_o       = led_q;
    assign harness.state_o     = state_q;

endmodule

// File: tb/tb_chip_reset_seq.sv
// tb_chip_reset_seq: directed bench for chip_reset_seq with
// SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, RESET_HOLD_CYCLES=4, HEARTBEAT_BIT=3.
// Build with CHIP_RESET_SEQ_HEARTBEAT_EN defined to also exercise the blink.
module tb_chip_reset_seq;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    chip_reset_seq_if sys ();

    chip_reset_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (16),
        .RESET_HOLD_CYCLES  (4),
        .HEARTBEAT_BIT      (3)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .harness (sys)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        int         edges;
        logic       locked;
        logic       success;
        logic       exp_rst;
        logic       exp_led;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic r, input logic l, input logic [1:0] s);
        chk({nm, ".sys_reset"}, {1'b0, sys.sys_reset_o}, {1'b0, r});
        chk({nm, ".led"},       {1'b0, sys.led_o},       {1'b0, l});
        chk({nm, ".state"},     sys.state_o,             s);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Inputs change 1 time unit after an edge; the first edge afterwards
        // samples them, locked_s follows on the second, the FSM on the third.
        vecs.push_back('{"lock_sync",       2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{"hold_to_stable",  1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"stable_last",    15, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"to_release",      1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2});
        vecs.push_back('{"release_last",    3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2});
        vecs.push_back('{"to_run",          1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3});
        vecs.push_back('{"success_pulse",   1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{"led_sticky",      5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{"loss_in_sync",    2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3});
        vecs.push_back('{"loss_to_hold",    1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{"relock_stable",   3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"stable_count",    5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"glitch_low",      1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"glitch_back",     1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"glitch_hold",     1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{"restart_stable",  1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1});
        vecs.push_back('{"restart_release",16, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2});
        vecs.push_back('{"restart_hold",    3, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2});
        vecs.push_back('{"restart_run",     1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3});

        sys.locked_i  = 1'b0;
        sys.success_i = 1'b0;

        // Reset state while resetn is held low across edges.
        step(3);
        chk_all("reset", 1'b1, 1'b0, 2'd0);
        #2 resetn = 1'b1;
        step(2);
        chk_all("idle_unlocked", 1'b1, 1'b0, 2'd0);

        // Table-driven bring-up, lock loss, glitch and relock.
        for (int i = 0; i < vecs.size(); i++) begin
            sys.locked_i  = vecs[i].locked;
            sys.success_i = vecs[i].success;
            step(vecs[i].edges);
            chk_all(vecs[i].name, vecs[i].exp_rst, vecs[i].exp_led, vecs[i].exp_state);
        end

        // Async reset mid-RELEASE, between clock edges.
        sys.locked_i = 1'b0;
        step(3);
        chk_all("drop_for_ar", 1'b1, 1'b0, 2'd0);
        sys.locked_i = 1'b1;
        step(3 + 16 + 2);
        chk_all("ar_in_release", 1'b1, 1'b0, 2'd2);
        #2 resetn = 1'b0;
        #1;
        chk_all("ar_immediate", 1'b1, 1'b0, 2'd0);
        #1 resetn = 1'b1;
        // Synchronizer was cleared, so lock must travel through it again.
        step(2);
        chk_all("ar_resync", 1'b1, 1'b0, 2'd0);
        step(1);
        chk_all("ar_stable", 1'b1, 1'b0, 2'd1);
        step(16 + 4);
        chk_all("ar_run", 1'b0, 1'b0, 2'd3);

`ifdef CHIP_RESET_SEQ_HEARTBEAT_EN
        // Heartbeat bit 3: dark for 8 edges, lit for 8, dark again.
        step(8);
        chk_all("hb_k8", 1'b0, 1'b0, 2'd3);
        step(1);
        chk_all("hb_k9", 1'b0, 1'b1, 2'd3);
        step(7);
        chk_all("hb_k16", 1'b0, 1'b1, 2'd3);
        step(1);
        chk_all("hb_k17", 1'b0, 1'b0, 2'd3);
`endif

        // Success latches the LED; async reset in RUN clears everything.
        sys.success_i = 1'b1;
        step(1);
        sys.success_i = 1'b0;
        chk_all("run_success", 1'b0, 1'b1, 2'd3);
        step(10);
        chk_all("run_success_hold", 1'b0, 1'b1, 2'd3);
        #3 resetn = 1'b0;
        #1;
        chk_all("ar_in_run", 1'b1, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
